seq_alu: RTL and testbench

Parametrised, handshaked successor to the 6-bit combinational ALU. Operands enter through a valid/ready input port, results leave through a valid/ready output port with a registered flag set. The block adds XOR and a multi-cycle shift-add unsigned multiply with a double-width result. It is the datapath building block for sequential processing blocks that need back-pressure and multi-cycle operations.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_mul_seq.sv | 53 +++++
 rtl/seq_alu.sv | 173 +++++++++++++++++
 tb/tb_seq_alu.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU slice.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_ILL6 = 3'b110,
        ALU_ILL7 = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        DONE
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add unsigned multiplier: one partial product per cycle,
// WIDTH iterations, double-width product.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    // Load operands on start, then add one shifted partial product per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (busy) begin
            if (cnt == CNT_W'(WIDTH)) begin
                busy <= 1'b0;
            end else begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
            end
        end
    end

    assign done    = busy && (cnt == CNT_W'(WIDTH));
    assign product = acc;

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: captures operands on accept, runs a single-cycle op or the
// shift-add multiplier, and holds a registered result until consumed.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0] op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic            cout,
    output logic            ovf,
    output logic            zero,
    output logic            err
);

    alu_state_e         state;
    alu_state_e         state_next;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    alu_op_e            op_q;
    logic               exec_stage;
    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cout;
    logic               alu_ovf;
    logic               alu_err;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (alu_op_e'(op) == ALU_MUL);

    alu_mul_seq #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; EXEC lasts two cycles (settle, then register on entry to DONE).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (alu_op_e'(op) == ALU_MUL) ? MUL : EXEC;
                end
            end
            EXEC: begin
                if (exec_stage) begin
                    state_next = DONE;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_next = DONE;
                end else if (!mul_busy) begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture on accept and the EXEC settle-cycle marker.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= ALU_ADD;
            exec_stage <= 1'b0;
        end else begin
            if (accept) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= alu_op_e'(op);
            end
            exec_stage <= (state == EXEC) && !exec_stage;
        end
    end

    // Single-cycle datapath from the captured operands.
    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        alu_err  = 1'b0;
        case (op_q)
            ALU_ADD: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res  = diff[WIDTH-1:0];
                alu_cout = diff[WIDTH];
                alu_ovf  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            ALU_AND: alu_res = a_q & b_q;
            ALU_OR:  alu_res = a_q | b_q;
            ALU_XOR: alu_res = a_q ^ b_q;
            ALU_MUL: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    // Output registers load only on the transition into DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result    <= '0;
            result_hi <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
        end else if ((state == EXEC) && exec_stage) begin
            result    <= alu_res;
            result_hi <= '0;
            cout      <= alu_cout;
            ovf       <= alu_ovf;
            zero      <= (alu_res == '0);
            err       <= alu_err;
        end else if ((state == MUL) && mul_done) begin
            result    <= mul_product[WIDTH-1:0];
            result_hi <= mul_product[2*WIDTH-1:WIDTH];
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= (mul_product == '0);
            err       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=6.
module tb_seq_alu;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] a;
    logic [5:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] result;
    logic [5:0] result_hi;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op and wait (bounded) for out_valid; lat counts edges after accept.
    task automatic run_op(input logic [5:0] va, input logic [5:0] vb,
                          input logic [2:0] vop, output int lat);
        a = va; b = vb; op = vop; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~va; b = ~vb; op = 3'b111;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1; a = 6'd1; b = 6'd1; op = 3'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if ({result_hi, result, cout, ovf, zero, err} !== 16'h0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0", {result_hi, result, cout, ovf, zero, err});
        end
    endtask

    task automatic test_add;
        int lat;
        run_op(6'd59, 6'd20, 3'd0, lat);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL add_latency: got %0d expected 2", lat); end
        n_cmp++; if (result !== 6'd15) begin n_err++; $display("FAIL add_result: got %0d expected 15", result); end
        n_cmp++; if ({cout, ovf, zero, err} !== 4'b1000) begin n_err++; $display("FAIL add_flags: got %b expected 1000", {cout, ovf, zero, err}); end
        n_cmp++; if (result_hi !== 6'd0) begin n_err++; $display("FAIL add_hi: got %0d expected 0", result_hi); end
        consume();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL add_consume: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
        end
        run_op(6'd31, 6'd1, 3'd0, lat);
        n_cmp++; if (result !== 6'd32) begin n_err++; $display("FAIL add_ovf_result: got %0d expected 32", result); end
        n_cmp++; if ({cout, ovf, zero, err} !== 4'b0100) begin n_err++; $display("FAIL add_ovf_flags: got %b expected 0100", {cout, ovf, zero, err}); end
        consume();
    endtask

    task automatic test_sub;
        int lat;
        run_op(6'd5, 6'd10, 3'd1, lat);
        n_cmp++; if (result !== 6'd59) begin n_err++; $display("FAIL sub_borrow_result: got %0d expected 59", result); end
        n_cmp++; if ({cout, ovf, zero, err} !== 4'b0000) begin n_err++; $display("FAIL sub_borrow_flags: got %b expected 0000", {cout, ovf, zero, err}); end
        consume();
        run_op(6'd20, 6'd20, 3'd1, lat);
        n_cmp++; if (result !== 6'd0) begin n_err++; $display("FAIL sub_equal_result: got %0d expected 0", result); end
        n_cmp++; if ({cout, ovf, zero, err} !== 4'b1010) begin n_err++; $display("FAIL sub_equal_flags: got %b expected 1010", {cout, ovf, zero, err}); end
        consume();
        run_op(6'd32, 6'd1, 3'd1, lat);
        n_cmp++; if (result !== 6'd31 || ovf !== 1'b1 || cout !== 1'b1) begin
            n_err++; $display("FAIL sub_ovf: got res=%0d ovf=%b cout=%b expected 31/1/1", result, ovf, cout);
        end
        consume();
    endtask

    task automatic test_logic;
        int lat;
        logic [2:0]  ops [3] = '{3'd2, 3'd3, 3'd4};
        logic [5:0]  exps[3] = '{6'd2, 6'd63, 6'd61};
        for (int i = 0; i < 3; i++) begin
            run_op(6'd30, 6'd35, ops[i], lat);
            n_cmp++; if (result !== exps[i] || {cout, ovf, err} !== 3'b000 || lat !== 2) begin
                n_err++; $display("FAIL logic_op%0d: got res=%0d flags=%b lat=%0d expected %0d/000/2",
                                  ops[i], result, {cout, ovf, err}, lat, exps[i]);
            end
            consume();
        end
    endtask

    task automatic test_illegal;
        int lat;
        logic [2:0] ill [2] = '{3'd6, 3'd7};
        for (int i = 0; i < 2; i++) begin
            run_op(6'd17, 6'd9, ill[i], lat);
            n_cmp++; if ({result_hi, result} !== 12'd0 || err !== 1'b1 || zero !== 1'b1 || lat !== 2) begin
                n_err++; $display("FAIL illegal_op%0d: got res=%0d hi=%0d err=%b zero=%b lat=%0d expected 0/0/1/1/2",
                                  ill[i], result, result_hi, err, zero, lat);
            end
            consume();
        end
    endtask

    task automatic test_mul;
        int lat;
        int rdy_bad;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mul_pre_ready: got %b expected 1", in_ready); end
        a = 6'd15; b = 6'd25; op = 3'd5; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 6'd0; b = 6'd0; op = 3'd0;
        lat = 0; rdy_bad = 0;
        while (!out_valid && lat < 50) begin
            if (in_ready) rdy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (lat !== 7) begin n_err++; $display("FAIL mul_latency: got %0d expected 7", lat); end
        n_cmp++; if (rdy_bad !== 0) begin n_err++; $display("FAIL mul_in_ready_low: got %0d high cycles expected 0", rdy_bad); end
        n_cmp++; if (result_hi !== 6'd5 || result !== 6'd55) begin
            n_err++; $display("FAIL mul_product: got hi=%0d lo=%0d expected 5/55", result_hi, result);
        end
        n_cmp++; if ({cout, ovf, zero, err} !== 4'b0000) begin n_err++; $display("FAIL mul_flags: got %b expected 0000", {cout, ovf, zero, err}); end
        consume();
    endtask

    task automatic test_back_to_back;
        int lat;
        int unstable;
        run_op(6'd3, 6'd4, 3'd0, lat);
        a = 6'd10; b = 6'd5; op = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (result !== 6'd7 || out_valid !== 1'b1 || in_ready !== 1'b0 || err !== 1'b0) unstable++;
        end
        n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", unstable); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_next_accept: got ready=%b expected 0", in_ready); end
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (lat !== 2 || result !== 6'd15) begin
            n_err++; $display("FAIL bp_next_result: got lat=%0d res=%0d expected 2/15", lat, result);
        end
        consume();
    endtask

    task automatic test_reset_mul;
        int lat;
        int stray;
        a = 6'd63; b = 6'd63; op = 3'd5; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++; if ({result_hi, result, cout, ovf, zero, err} !== 16'h0) begin
            n_err++; $display("FAIL midmul_reset_outputs: got %h expected 0", {result_hi, result, cout, ovf, zero, err});
        end
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL midmul_reset_handshake: got ready=%b valid=%b expected 1/0", in_ready, out_valid);
        end
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stray++;
        end
        n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL midmul_no_stray: got %0d bad cycles expected 0", stray); end
        run_op(6'd1, 6'd1, 3'd0, lat);
        n_cmp++; if (lat !== 2 || result !== 6'd2 || result_hi !== 6'd0) begin
            n_err++; $display("FAIL post_reset_add: got lat=%0d res=%0d hi=%0d expected 2/2/0", lat, result, result_hi);
        end
        consume();
        run_op(6'd63, 6'd63, 3'd5, lat);
        n_cmp++; if (lat !== 7 || result_hi !== 6'd62 || result !== 6'd1) begin
            n_err++; $display("FAIL post_reset_mul: got lat=%0d hi=%0d lo=%0d expected 7/62/1", lat, result_hi, result);
        end
        consume();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_illegal();
        test_mul();
        test_back_to_back();
        test_reset_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
